// File: rtl/kid_collision_detector_pkg.sv
// Shared game definitions: screen geometry, overlap counter width and the
// collision detector state encoding.
package game_pkg;
    localparam int SCREEN_W      = 800;
    localparam int SCREEN_H      = 600;
    localparam int OVERLAP_CNT_W = 12;
    localparam int POS_W         = 10;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        SCAN     = 2'd1,
        EVAL     = 2'd2,
        DEAD     = 2'd3
    } det_state_t;
endpackage

// File: rtl/kid_collision_detector_if.sv
// Sprite pixel stream into the collision detector and its per-frame results.
// master = pixel/respawn source, slave = detector.
interface kid_collision_detector_if #(
    parameter int COUNT_W = game_pkg::OVERLAP_CNT_W
);
    import game_pkg::*;

    logic               pix_en;
    logic [POS_W-1:0]   col;
    logic [POS_W-1:0]   row;
    logic               is_kid;
    logic               is_apple;
    logic               respawn;
    logic               frame_done;
    logic               hit;
    logic               dead;
    logic [COUNT_W-1:0] overlap_cnt;
    logic [POS_W-1:0]   hit_col;
    logic [POS_W-1:0]   hit_row;

    modport master (
        output pix_en, col, row, is_kid, is_apple, respawn,
        input  frame_done, hit, dead, overlap_cnt, hit_col, hit_row
    );

    modport slave (
        input  pix_en, col, row, is_kid, is_apple, respawn,
        output frame_done, hit, dead, overlap_cnt, hit_col, hit_row
    );
endinterface

// File: rtl/kid_collision_detector_sat_counter.sv
// Saturating up-counter: clear has priority and loads the current increment,
// so a clear and a count on the same edge yields 1.
module sat_counter #(
    parameter int COUNT_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? COUNT_W'(1) : '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end
endmodule

// File: rtl/kid_collision_detector.sv
// Counts kid/apple overlap pixels per frame and raises hit/dead at end of frame.
// Define HIT_POS_LATCH_EN to publish the first overlap position on hit_col/hit_row.
module kid_collision_detector #(
    parameter int SCREEN_W    = game_pkg::SCREEN_W,
    parameter int SCREEN_H    = game_pkg::SCREEN_H,
    parameter int MIN_OVERLAP = 4,
    parameter int COUNT_W     = game_pkg::OVERLAP_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    kid_collision_detector_if.slave bus
);
    import game_pkg::*;

    localparam logic [POS_W:0]   COL_LIM  = (POS_W + 1)'(SCREEN_W);
    localparam logic [POS_W:0]   ROW_LIM  = (POS_W + 1)'(SCREEN_H);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(SCREEN_W - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(SCREEN_H - 1);

    det_state_t         state;
    det_state_t         nxt_state;
    logic               qual;
    logic               ovl;
    logic               sof;
    logic               eof;
    logic               thr;
    logic               acc_clr;
    logic               acc_inc;
    logic [COUNT_W-1:0] acc;
    logic               publish;
    logic               set_dead;
    logic               clr_dead;
    logic               frame_done;
    logic               hit;
    logic               dead_q;
    logic [COUNT_W-1:0] cnt_q;

    assign qual = bus.pix_en && ({1'b0, bus.col} < COL_LIM) && ({1'b0, bus.row} < ROW_LIM);
    assign ovl  = qual && bus.is_kid && bus.is_apple;
    assign sof  = qual && (bus.col == '0) && (bus.row == '0);
    assign eof  = qual && (bus.col == LAST_COL) && (bus.row == LAST_ROW);
    assign thr  = (acc >= COUNT_W'(MIN_OVERLAP));

    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .inc   (acc_inc),
        .count (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= nxt_state;
        end
    end

    // A (0,0) pixel always restarts the frame: clear and count in the same edge.
    always_comb begin
        nxt_state  = state;
        acc_clr    = 1'b0;
        acc_inc    = 1'b0;
        publish    = 1'b0;
        set_dead   = 1'b0;
        clr_dead   = 1'b0;
        frame_done = 1'b0;
        hit        = 1'b0;
        unique case (state)
            WAIT_SOF: begin
                if (bus.respawn) begin
                    acc_clr = 1'b1;
                end else if (sof) begin
                    acc_clr   = 1'b1;
                    acc_inc   = ovl;
                    nxt_state = SCAN;
                end
            end
            SCAN: begin
                if (bus.respawn) begin
                    acc_clr   = 1'b1;
                    nxt_state = WAIT_SOF;
                end else if (sof) begin
                    acc_clr = 1'b1;
                    acc_inc = ovl;
                end else begin
                    acc_inc = ovl;
                    if (eof) begin
                        nxt_state = EVAL;
                    end
                end
            end
            EVAL: begin
                frame_done = 1'b1;
                publish    = 1'b1;
                acc_clr    = 1'b1;
                nxt_state  = WAIT_SOF;
                if (thr) begin
                    hit = 1'b1;
                    if (!bus.respawn) begin
                        set_dead  = 1'b1;
                        nxt_state = DEAD;
                    end
                end
            end
            DEAD: begin
                if (bus.respawn) begin
                    clr_dead  = 1'b1;
                    nxt_state = WAIT_SOF;
                end
            end
            default: nxt_state = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (set_dead) begin
                dead_q <= 1'b1;
            end else if (clr_dead) begin
                dead_q <= 1'b0;
            end
            if (publish) begin
                cnt_q <= acc;
            end
        end
    end

    assign bus.frame_done  = frame_done;
    assign bus.hit         = hit;
    assign bus.dead        = dead_q;
    assign bus.overlap_cnt = cnt_q;

`ifdef HIT_POS_LATCH_EN
    // The shadow tracks the accumulator: cleared with it, captured on its first count.
    logic             shd_vld;
    logic             shd_cap;
    logic [POS_W-1:0] shd_col;
    logic [POS_W-1:0] shd_row;
    logic [POS_W-1:0] hit_col_q;
    logic [POS_W-1:0] hit_row_q;

    assign shd_cap = acc_inc && (acc_clr || !shd_vld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_vld <= 1'b0;
        end else if (shd_cap) begin
            shd_vld <= 1'b1;
        end else if (acc_clr) begin
            shd_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (shd_cap) begin
            shd_col <= bus.col;
            shd_row <= bus.row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_col_q <= '0;
            hit_row_q <= '0;
        end else if (publish) begin
            hit_col_q <= shd_vld ? shd_col : '0;
            hit_row_q <= shd_vld ? shd_row : '0;
        end
    end

    assign bus.hit_col = hit_col_q;
    assign bus.hit_row = hit_row_q;
`else
    assign bus.hit_col = '0;
    assign bus.hit_row = '0;
`endif
endmodule
